// File: rtl/mem_load_unit.sv
// Load-side front end of the MEM stage: issues one RV32 load to the read arbiter,
// extracts and extends the addressed byte/half/word, and hands it to writeback.
module mem_load_unit #(
    parameter int BUS_W  = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_addr,
    input  logic [2:0]        ld_funct3,
    input  logic [4:0]        ld_rd,
    output logic [31:0]       mem_raddr,
    output logic [2:0]        mem_rsize,
    output logic              mem_raddr_valid,
    input  logic              mem_raddr_ready,
    input  logic [BUS_W-1:0]  mem_rdata,
    input  logic              mem_rdata_valid,
    output logic              mem_rdata_ready,
    input  logic              mem_bus_err,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t              state, state_nxt;
    logic [31:0]         addr_q;
    logic [2:0]          funct3_q;
    logic [4:0]          rd_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic                wb_err_q;
    logic                ld_legal;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   extended;
    logic                sign_ext;

    // Misaligned halves/words and funct3 3/6/7 never reach the bus.
    always_comb begin
        ld_legal = 1'b0;
        case (ld_funct3)
            3'd0, 3'd4: ld_legal = 1'b1;
            3'd1, 3'd5: ld_legal = ~ld_addr[0];
            3'd2:       ld_legal = (ld_addr[1:0] == 2'b00);
            default:    ld_legal = 1'b0;
        endcase
    end

    assign shifted  = DATA_W'(mem_rdata >> {addr_q[2:0], 3'b000});
    assign sign_ext = ~funct3_q[2];

    always_comb begin
        extended = shifted;
        case (funct3_q[1:0])
            2'd0:    extended = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            2'd1:    extended = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: extended = shifted;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaulting state_nxt first keeps this block free of latches.
        state_nxt = state;
        case (state)
            S_IDLE: if (ld_valid)        state_nxt = ld_legal ? S_REQ : S_RESP;
            S_REQ:  if (mem_raddr_ready) state_nxt = S_WAIT;
            S_WAIT: if (mem_rdata_valid) state_nxt = S_RESP;
            S_RESP: if (wb_ready)        state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && ld_valid) begin
                addr_q   <= ld_addr;
                funct3_q <= ld_funct3;
                rd_q     <= ld_rd;
                if (!ld_legal) begin
                    wb_data_q <= '0;
                    wb_err_q  <= 1'b1;
                end
            end
            // A bus error still captures the extracted value; wb_err flags it.
            if (state == S_WAIT && mem_rdata_valid) begin
                wb_data_q <= extended;
                wb_err_q  <= mem_bus_err;
            end
        end
    end

    always_comb begin
        ld_ready        = (state == S_IDLE);
        mem_raddr_valid = (state == S_REQ);
        mem_rdata_ready = (state == S_WAIT);
        wb_valid        = (state == S_RESP);
        mem_raddr       = addr_q;
        mem_rsize       = {1'b0, funct3_q[1:0]};
        wb_data         = wb_data_q;
        wb_rd           = rd_q;
        wb_err          = wb_err_q;
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Table-driven bench for mem_load_unit with a scoreboard queue of writeback results
// and hand-written reset-in-flight sequence.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic [4:0]  ld_rd;
    logic [31:0] mem_raddr;
    logic [2:0]  mem_rsize;
    logic        mem_raddr_valid;
    logic        mem_raddr_ready;
    logic [63:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        mem_rdata_ready;
    logic        mem_bus_err;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;

    always #5 clk = ~clk;

    mem_load_unit #(.BUS_W(64), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_funct3(ld_funct3), .ld_rd(ld_rd),
        .mem_raddr(mem_raddr), .mem_rsize(mem_rsize),
        .mem_raddr_valid(mem_raddr_valid), .mem_raddr_ready(mem_raddr_ready),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata_ready(mem_rdata_ready), .mem_bus_err(mem_bus_err),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_err(wb_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        bus_err;
        logic        bus;
        logic [2:0]  rsize;
        int          rdly;
        int          wdly;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        logic saw_req;
        exp_t e;
        check("ld_ready before load", ld_ready, 1);
        ld_valid  = 1'b1;
        ld_addr   = v.addr;
        ld_funct3 = v.funct3;
        ld_rd     = v.rd;
        sb.push_back('{v.exp_data, v.rd, v.exp_err});
        step();
        ld_valid = 1'b0;
        ld_addr  = $urandom;
        if (v.bus) begin
            check("raddr_valid one cycle after ld", mem_raddr_valid, 1);
            check("mem_raddr", mem_raddr, v.addr);
            check("mem_rsize", mem_rsize, v.rsize);
            for (int i = 0; i < v.rdly; i++) begin
                step();
                check("raddr_valid held", mem_raddr_valid, 1);
                check("mem_raddr stable", mem_raddr, v.addr);
                check("mem_rsize stable", mem_rsize, v.rsize);
            end
            mem_raddr_ready = 1'b1;
            step();
            mem_raddr_ready = 1'b0;
            check("raddr_valid dropped", mem_raddr_valid, 0);
            check("rdata_ready in wait", mem_rdata_ready, 1);
            mem_rdata       = v.rdata;
            mem_rdata_valid = 1'b1;
            mem_bus_err     = v.bus_err;
            step();
            mem_rdata_valid = 1'b0;
            mem_bus_err     = 1'b0;
            mem_rdata       = {$urandom, $urandom};
            check("wb_valid after beat", wb_valid, 1);
        end else begin
            n       = 0;
            saw_req = 1'b0;
            while (!wb_valid && n < 2) begin
                saw_req = saw_req | mem_raddr_valid;
                step();
                n++;
            end
            check("wb_valid on illegal load", wb_valid, 1);
            check("no bus request on illegal", saw_req | mem_raddr_valid, 0);
        end
        e = sb[0];
        for (int i = 0; i < v.wdly; i++) begin
            wb_ready = 1'b0;
            step();
            check("wb_valid held", wb_valid, 1);
            check("wb_data stable", wb_data, e.data);
            check("wb_err stable", wb_err, e.err);
            check("ld_ready low in resp", ld_ready, 0);
        end
        e = sb.pop_front();
        check("wb_data", wb_data, e.data);
        check("wb_rd", wb_rd, e.rd);
        check("wb_err", wb_err, e.err);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check("wb_valid after wb handshake", wb_valid, 0);
        check("ld_ready after wb handshake", ld_ready, 1);
    endtask

    initial begin
        //          addr          f3    rd     rdata                  berr bus  rsz  rdly wdly exp_data       err
        vecs[0]  = '{32'h8000_0004, 3'd2, 5'd1,  64'h1122_3344_5566_7788, 1'b0, 1'b1, 3'd2, 0, 0, 32'h1122_3344, 1'b0};
        vecs[1]  = '{32'h8000_0003, 3'd0, 5'd2,  64'h0000_0000_8000_0000, 1'b0, 1'b1, 3'd0, 0, 0, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{32'h8000_0003, 3'd4, 5'd3,  64'h0000_0000_8000_0000, 1'b0, 1'b1, 3'd0, 0, 0, 32'h0000_0080, 1'b0};
        vecs[3]  = '{32'h8000_0006, 3'd1, 5'd4,  64'hF00D_0000_0000_0000, 1'b0, 1'b1, 3'd1, 5, 0, 32'hFFFF_F00D, 1'b0};
        vecs[4]  = '{32'h8000_0006, 3'd5, 5'd5,  64'hF00D_0000_0000_0000, 1'b0, 1'b1, 3'd1, 0, 4, 32'h0000_F00D, 1'b0};
        vecs[5]  = '{32'h8000_0002, 3'd2, 5'd6,  64'h0,                   1'b0, 1'b0, 3'd2, 0, 0, 32'h0,         1'b1};
        vecs[6]  = '{32'h8000_0001, 3'd1, 5'd7,  64'h0,                   1'b0, 1'b0, 3'd1, 0, 0, 32'h0,         1'b1};
        vecs[7]  = '{32'h8000_0000, 3'd3, 5'd8,  64'h0,                   1'b0, 1'b0, 3'd3, 0, 2, 32'h0,         1'b1};
        vecs[8]  = '{32'h8000_0000, 3'd2, 5'd9,  64'hDEAD_BEEF_CAFE_BABE, 1'b1, 1'b1, 3'd2, 1, 0, 32'hCAFE_BABE, 1'b1};
        vecs[9]  = '{32'h8000_0007, 3'd0, 5'd10, 64'h7F11_2233_4455_6677, 1'b0, 1'b1, 3'd0, 0, 0, 32'h0000_007F, 1'b0};
        vecs[10] = '{32'h8000_0000, 3'd6, 5'd11, 64'h0,                   1'b0, 1'b0, 3'd2, 0, 0, 32'h0,         1'b1};
        vecs[11] = '{32'h8000_0002, 3'd5, 5'd12, 64'hAAAA_BBBB_8765_CCCC, 1'b0, 1'b1, 3'd1, 2, 1, 32'h0000_8765, 1'b0};
        vecs[12] = '{32'h8000_0002, 3'd1, 5'd13, 64'hAAAA_BBBB_8765_CCCC, 1'b0, 1'b1, 3'd1, 0, 0, 32'hFFFF_8765, 1'b0};

        rst             = 1'b1;
        ld_valid        = 1'b0;
        ld_addr         = '0;
        ld_funct3       = '0;
        ld_rd           = '0;
        mem_raddr_ready = 1'b0;
        mem_rdata       = '0;
        mem_rdata_valid = 1'b0;
        mem_bus_err     = 1'b0;
        wb_ready        = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        check("reset ld_ready", ld_ready, 1);
        check("reset raddr_valid", mem_raddr_valid, 0);
        check("reset rdata_ready", mem_rdata_ready, 0);
        check("reset wb_valid", wb_valid, 0);
        check("reset mem_raddr", mem_raddr, 0);
        check("reset mem_rsize", mem_rsize, 0);
        check("reset wb_data", wb_data, 0);
        check("reset wb_rd", wb_rd, 0);
        check("reset wb_err", wb_err, 0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset while waiting for the read beat drops the load.
        ld_valid  = 1'b1;
        ld_addr   = 32'h8000_0010;
        ld_funct3 = 3'd2;
        ld_rd     = 5'd20;
        step();
        ld_valid        = 1'b0;
        mem_raddr_ready = 1'b1;
        step();
        mem_raddr_ready = 1'b0;
        check("mid-op reached wait", mem_rdata_ready, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid-op reset ld_ready", ld_ready, 1);
        check("mid-op reset raddr_valid", mem_raddr_valid, 0);
        check("mid-op reset rdata_ready", mem_rdata_ready, 0);
        check("mid-op reset wb_valid", wb_valid, 0);
        check("mid-op reset mem_raddr", mem_raddr, 0);
        run_vec('{32'h8000_0008, 3'd2, 5'd21, 64'h0BAD_F00D_1234_5678, 1'b0, 1'b1, 3'd2,
                  0, 0, 32'h1234_5678, 1'b0});

        check("scoreboard drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
